// File: rtl/pack_fifo_pkg.sv
// pack_fifo_pkg -- shared constants and lane placement helper for pack_fifo.
//
// Contents:
//   DEF_IN_W, DEF_RATIO, DEF_DEPTH : default parameter values for pack_fifo.
//   lane_offset()                  : bit offset of input lane k inside a packed word.
//
// Configuration macro: PACK_FIFO_MSB_FIRST_EN
//   undefined : lane k occupies bits [k*IN_W +: IN_W] (first word least significant).
//   defined   : lane k occupies bits [(RATIO-1-k)*IN_W +: IN_W] (first word most significant).
package pack_fifo_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_RATIO = 2;
  localparam int DEF_DEPTH = 32;

  // Out-of-range lanes map to offset 0 so callers never build an illegal select.
  function automatic int lane_offset(input int lane, input int ratio, input int in_w);
    if (lane < 0 || lane >= ratio) begin
      return 0;
    end
`ifdef PACK_FIFO_MSB_FIRST_EN
    return (ratio - 1 - lane) * in_w;
`else
    return lane * in_w;
`endif
  endfunction

endpackage

// File: rtl/pack_fifo_packer.sv
// pack_fifo_packer -- accumulates RATIO input words into one packed word.
//
// Ports:
//   clk        : clock, rising edge.
//   rst        : asynchronous active-high reset (lane counter only).
//   flush      : synchronous clear; discards any partial word.
//   accept     : an input word is taken this cycle.
//   in_data    : input word (IN_W bits).
//   lane_last  : lane counter currently points at the final lane.
//   word_done  : strobe, the word completing on this edge is on word_data.
//   word_data  : partial word with the current input merged into its lane.
//
// Lane order is chosen by PACK_FIFO_MSB_FIRST_EN through pack_fifo_pkg::lane_offset.
module pack_fifo_packer
  import pack_fifo_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int RATIO = DEF_RATIO
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    accept,
  input  logic [IN_W-1:0]         in_data,
  output logic                    lane_last,
  output logic                    word_done,
  output logic [IN_W*RATIO-1:0]   word_data
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int LW    = $clog2(RATIO);
  localparam logic [LW-1:0] LANE_LAST = LW'(RATIO - 1);

  logic [LW-1:0]    lane_p0;
  logic [OUT_W-1:0] partial_p0;

  assign lane_last = (lane_p0 == LANE_LAST);
  assign word_done = accept && lane_last && !flush;

  // Merge the incoming word into the held partial so the final lane can be
  // written to storage on the same edge that accepts it.
  always_comb begin
    word_data = partial_p0;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_p0 == LW'(k)) begin
        word_data[lane_offset(k, RATIO, IN_W) +: IN_W] = in_data;
      end
    end
  end

  // Stage p0: lane counter (control) and partial word (data, not reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_p0 <= '0;
    end else if (flush) begin
      lane_p0 <= '0;
    end else if (accept) begin
      lane_p0 <= lane_last ? '0 : lane_p0 + LW'(1);
    end
  end

  // Stale lanes are always overwritten before a word completes.
  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      partial_p0 <= word_data;
    end
  end

endmodule

// File: rtl/pack_fifo.sv
// pack_fifo -- width-packing FIFO: RATIO narrow input words form one wide
// stored word, presented first-word-fall-through.
//
// Parameters: IN_W (input width), RATIO (2..8 words per output word),
//             DEPTH (power of two >= 4, storage in output words).
// Ports:
//   clk       : clock, rising edge.
//   rst       : asynchronous active-high reset (pointers, lane counter).
//   flush     : synchronous clear of all contents, overrides push and pop.
//   in_data   : input word;         in_valid / in_ready handshake.
//   out_data  : packed head word;   out_valid / out_ready handshake.
//   level     : number of stored complete words, 0..DEPTH.
//
// Configuration macro: PACK_FIFO_MSB_FIRST_EN (lane order, see pack_fifo_pkg).
module pack_fifo
  import pack_fifo_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int RATIO = DEF_RATIO,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [IN_W*RATIO-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int AW    = $clog2(DEPTH);

  logic [AW:0]      wptr_p0;
  logic [AW:0]      rptr_p0;
  logic [OUT_W-1:0] mem [DEPTH];

  logic             full;
  logic             empty;
  logic             accept;
  logic             lane_last;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] word_data;

  assign full  = (wptr_p0[AW] != rptr_p0[AW]) && (wptr_p0[AW-1:0] == rptr_p0[AW-1:0]);
  assign empty = (wptr_p0 == rptr_p0);
  assign level = wptr_p0 - rptr_p0;

  // Stall only when the next accept would complete a word that has no room;
  // deliberately independent of out_ready to keep the path combinationally short.
  assign in_ready  = !lane_last || !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign out_data  = mem[rptr_p0[AW-1:0]];
  assign pop       = out_valid && out_ready && !flush;

  pack_fifo_packer #(
    .IN_W  (IN_W),
    .RATIO (RATIO)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .accept    (accept),
    .in_data   (in_data),
    .lane_last (lane_last),
    .word_done (push),
    .word_data (word_data)
  );

  // Stage p0: pointer update; level follows from the pointer difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_p0 <= '0;
      rptr_p0 <= '0;
    end else if (flush) begin
      wptr_p0 <= '0;
      rptr_p0 <= '0;
    end else begin
      if (push) begin
        wptr_p0 <= wptr_p0 + (AW+1)'(1);
      end
      if (pop) begin
        rptr_p0 <= rptr_p0 + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_p0[AW-1:0]] <= word_data;
    end
  end

endmodule

// File: tb/tb_pack_fifo.sv
module tb_pack_fifo;

  localparam int IN_W  = 8;
  localparam int RATIO = 2;
  localparam int DEPTH = 32;
  localparam int OUT_W = IN_W * RATIO;
  localparam int AW    = $clog2(DEPTH);

`ifdef PACK_FIFO_MSB_FIRST_EN
  localparam logic [15:0] EXP_2211 = 16'h1122;
  localparam logic [15:0] EXP_BBAA = 16'hAABB;
  localparam logic [15:0] EXP_C35A = 16'h5AC3;
  localparam logic [15:0] EXP_B4   = 16'h1234;
`else
  localparam logic [15:0] EXP_2211 = 16'h2211;
  localparam logic [15:0] EXP_BBAA = 16'hBBAA;
  localparam logic [15:0] EXP_C35A = 16'hC35A;
  localparam logic [15:0] EXP_B4   = 16'h4321;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      level;

  logic             b_flush;
  logic [3:0]       b_in_data;
  logic             b_in_valid;
  logic             b_in_ready;
  logic [15:0]      b_out_data;
  logic             b_out_valid;
  logic             b_out_ready;
  logic [2:0]       b_level;

  pack_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  pack_fifo #(.IN_W(4), .RATIO(4), .DEPTH(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .level     (b_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_push = 0;
  int n_pop  = 0;

  // Reference model: bytes waiting to form a word, and complete stored words.
  logic [IN_W-1:0]  pend[$];
  logic [OUT_W-1:0] q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    return (pend.size() != RATIO - 1) || (q.size() != DEPTH);
  endfunction

  function automatic logic [OUT_W-1:0] model_word();
    logic [OUT_W-1:0] w;
    w = '0;
    for (int k = 0; k < RATIO; k++) begin
`ifdef PACK_FIFO_MSB_FIRST_EN
      w[(RATIO-1-k)*IN_W +: IN_W] = pend[k];
`else
      w[k*IN_W +: IN_W] = pend[k];
`endif
    end
    return w;
  endfunction

  task automatic model_clear();
    pend.delete();
    q.delete();
  endtask

  // One clock cycle: drive, compare against the model, clock, update the model.
  task automatic step(input logic iv, input logic [IN_W-1:0] d, input logic ordy);
    logic acc;
    logic pp;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    check("step.out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) check("step.out_data", 64'(out_data), 64'(q[0]));
    check("step.in_ready", 64'(in_ready), 64'(model_ready()));
    check("step.level", 64'(level), 64'(q.size()));
    acc = iv && model_ready();
    pp  = (q.size() != 0) && ordy;
    @(posedge clk);
    if (pp) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (acc) begin
      pend.push_back(d);
      if (pend.size() == RATIO) begin
        q.push_back(model_word());
        pend.delete();
        n_push++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    logic iv;
    logic ordy;
    logic [IN_W-1:0] d;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.level", 64'(level), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two bytes make one word, visible one cycle after the second accept.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    in_valid = 1'b0; #1;
    check("basic.out_valid", 64'(out_valid), 64'd1);
    check("basic.out_data", 64'(out_data), 64'(EXP_2211));
    check("basic.level", 64'(level), 64'd1);

    // Flush with a partial byte pending, while also offering input and output.
    step(1'b1, 8'h33, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    check("flush.level", 64'(level), 64'd0);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    in_valid = 1'b0; #1;
    check("flush.out_data", 64'(out_data), 64'(EXP_BBAA));
    while (q.size() != 0) step(1'b0, '0, 1'b1);

    // Fill to DEPTH words, then probe the full-boundary stall.
    for (int i = 0; i < DEPTH * RATIO; i++) step(1'b1, IN_W'($urandom), 1'b0);
    in_valid = 1'b1; #1;
    check("fill.level", 64'(level), 64'(DEPTH));
    check("fill.in_ready_lane0", 64'(in_ready), 64'd1);
    step(1'b1, IN_W'($urandom), 1'b0);
    in_valid = 1'b1; #1;
    check("fill.in_ready_lane1", 64'(in_ready), 64'd0);
    d = IN_W'($urandom);
    step(1'b1, d, 1'b0);
    check("fill.stalled_level", 64'(level), 64'(DEPTH));

    // Full plus pop: the pop frees room, the stalled byte goes in next edge.
    step(1'b1, d, 1'b1);
    #1;
    check("fullpop.level_after_pop", 64'(level), 64'(DEPTH - 1));
    step(1'b1, d, 1'b0);
    #1;
    check("fullpop.level_refill", 64'(level), 64'(DEPTH));
    cyc = 0;
    while (q.size() != 0 && cyc < 200) begin
      step(1'b0, '0, 1'b1);
      cyc++;
    end
    check("drain.level", 64'(level), 64'd0);

    // Wrap: stream 3*DEPTH words with random valid and toggling ready.
    n_push = 0; n_pop = 0; sent = 0; cyc = 0;
    while (sent < 3 * DEPTH * RATIO && cyc < 5000) begin
      iv   = ($urandom % 4) != 0;
      ordy = cyc[0] ^ (($urandom % 5) == 0);
      if (iv && model_ready()) sent++;
      step(iv, IN_W'($urandom), ordy);
      cyc++;
    end
    check("wrap.sent", 64'(sent), 64'(3 * DEPTH * RATIO));
    cyc = 0;
    while (q.size() != 0 && cyc < 200) begin
      step(1'b0, '0, 1'b1);
      cyc++;
    end
    check("wrap.pushed", 64'(n_push), 64'(3 * DEPTH));
    check("wrap.popped", 64'(n_pop), 64'(3 * DEPTH));
    check("wrap.level", 64'(level), 64'd0);

    // Asynchronous reset mid-stream, asserted between clock edges.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("areset.out_valid", 64'(out_valid), 64'd0);
    check("areset.in_ready", 64'(in_ready), 64'd1);
    check("areset.level", 64'(level), 64'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    in_valid = 1'b0; #1;
    check("areset.lane0", 64'(out_data), 64'(EXP_C35A));

    // Four-lane instance with 4-bit words: 1,2,3,4.
    for (int v = 1; v <= 4; v++) begin
      b_in_data  = 4'(v);
      b_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    b_in_valid = 1'b0; #1;
    check("ratio4.out_valid", 64'(b_out_valid), 64'd1);
    check("ratio4.out_data", 64'(b_out_data), 64'(EXP_B4));
    check("ratio4.level", 64'(b_level), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pack_fifo.md
PACK_FIFO -- requirements
Module: pack_fifo

Interface
REQ-001 SHALL have parameter IN_W, default 8, meaning input word width in bits.
REQ-002 SHALL have parameter RATIO, default 2, meaning input words packed per output word, allowed range 2..8.
REQ-003 SHALL have parameter DEPTH, default 32, meaning storage depth in output words, a power of two of at least 4.
REQ-004 SHALL derive OUT_W = IN_W*RATIO and AW = clog2(DEPTH); neither is overridable.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-008 SHALL have port in_data, input, IN_W bits: input word.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-010 SHALL have port in_ready, output, 1 bit: block can accept in_data this cycle.
REQ-011 SHALL have port out_data, output, OUT_W bits: packed head word.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data holds a stored word.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer takes out_data this cycle.
REQ-014 SHALL have port level, output, AW+1 bits: number of stored complete words, 0..DEPTH.

Function
REQ-015 SHALL accept an input word on every edge where in_valid && in_ready, and on no other edge.
REQ-016 SHALL pack accepted words into lanes by a lane counter 0..RATIO-1; the word at lane k goes to bits [k*IN_W +: IN_W] (default order).
REQ-017 SHALL write the packed word to storage on the edge accepting lane RATIO-1, then reset the lane counter to 0.
REQ-018 SHALL drive in_ready = (lane counter != RATIO-1) || (level != DEPTH), combinationally and independent of out_ready.
REQ-019 SHALL present the head word first-word-fall-through: out_valid = (level != 0), and out_data = storage at the read pointer.
REQ-020 SHALL pop one word on every edge where out_valid && out_ready.
REQ-021 SHALL raise out_valid in the cycle after the edge that completes the first word into an empty store, giving one-cycle latency.
REQ-022 SHALL use AW+1-bit read and write pointers with natural wrap-around: full when the MSBs differ and the low bits are equal, empty when the pointers are equal.
REQ-023 SHALL, on a simultaneous push and pop, keep level unchanged and advance both pointers.
REQ-024 SHALL hold out_data stable while out_valid && !out_ready.
REQ-025 SHALL, when flush is high at an edge, zero both pointers, the lane counter and level, and discard any partial word; flush overrides push and pop in that cycle.

Reset
REQ-026 SHALL, while rst is high, asynchronously force pointers, lane counter and level to 0, giving out_valid=0 and in_ready=1; storage contents are not reset.
REQ-027 SHALL, on reset mid-accumulation or mid-drain, lose all data, and the first word accepted after release lands in lane 0.

Configuration
REQ-028 SHALL support macro PACK_FIFO_MSB_FIRST_EN: when defined, the word at lane k goes to bits [(RATIO-1-k)*IN_W +: IN_W] so the first-received word is most significant; when undefined, the REQ-016 order applies; all timing is identical either way.

Structure
REQ-029 SHALL place default parameter constants and the lane-offset function (selected by PACK_FIFO_MSB_FIRST_EN) in shared package pack_fifo_pkg.
REQ-030 SHALL implement lane accumulation (lane counter, partial-word register, word-complete strobe) in sub-module pack_fifo_packer; pointers and storage stay in pack_fifo.

Verification
REQ-031 SHALL cover default params: push 0x11 then 0x22 -> out_data=0x2211 with out_valid=1 one cycle after the second accept, and level=1.
REQ-032 SHALL cover fill: 64 bytes with out_ready=0 -> level=32, in_ready=0 only when the lane counter is 1, and a 65th byte is accepted while the 66th is stalled.
REQ-033 SHALL cover full plus simultaneous pop: the 66th byte is offered with out_ready=1 -> pop accepted, then the 66th byte is accepted on the next edge and level returns to 32.
REQ-034 SHALL cover wrap: 3x DEPTH words streamed with out_ready toggling -> output order and values match a reference queue with no loss or duplication.
REQ-035 SHALL cover flush and reset: one byte then flush -> level=0 and the next two bytes 0xAA, 0xBB yield 0xBBAA; rst asserted mid-stream -> out_valid=0 immediately, without waiting for a clock edge.
REQ-036 SHALL cover the macro case: PACK_FIFO_MSB_FIRST_EN with IN_W=4, RATIO=4, pushing 1,2,3,4 -> out_data=16'h1234.
